// File: rtl/sha256_pkg.sv
// Shared constants and host FSM state type for the SHA-256 message host.
package sha256_pkg;
   localparam int MAX_MSG_BYTES = 55;
   localparam int DIGEST_BYTES  = 32;
   localparam int MSG_W         = 440;
   localparam int HASH_W        = 256;
   localparam int CNT_W         = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_ISSUE,
      ST_WAIT,
      ST_EMIT,
      ST_DRAIN
   } host_state_e;
endpackage

// File: rtl/sha256_digest_serializer.sv
// Loads a 256-bit digest and streams it MSB byte first with valid/ready/last.
module sha256_digest_serializer
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [HASH_W-1:0] load_data,
   output logic [7:0]        m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              done
);
   logic [HASH_W-1:0] sreg;
   logic [4:0]        idx;
   logic              vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         idx  <= '0;
         vld  <= 1'b0;
      end else if (load) begin
         sreg <= load_data;
         idx  <= '0;
         vld  <= 1'b1;
      end else if (vld && m_ready) begin
         // Clearing on the final byte returns m_data to zero between digests.
         if (idx == 5'(DIGEST_BYTES - 1)) begin
            sreg <= '0;
            idx  <= '0;
            vld  <= 1'b0;
         end else begin
            sreg <= {sreg[HASH_W-9:0], 8'h00};
            idx  <= idx + 5'd1;
         end
      end
   end

   assign m_data  = sreg[HASH_W-1 -: 8];
   assign m_valid = vld;
   assign m_last  = vld && (idx == 5'(DIGEST_BYTES - 1));
   assign done    = vld && m_ready && m_last;
endmodule

// File: rtl/sha256_msg_host.sv
// Byte-stream host for a single-block SHA-256 core: pack, issue, await, serialize.
// Define SHA256_HOST_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYCLES).
module sha256_msg_host
   import sha256_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [MSG_W-1:0]  data_in,
   output logic [CNT_W-1:0]  byte_valid,
   output logic              data_valid,
   output logic              msg_valid,
   input  logic [HASH_W-1:0] fin_hash,
   input  logic              hash_done,
   output logic [7:0]        m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              err
);
   host_state_e state, nxt;

   // Byte 0 is the most significant byte of the packed bus.
   logic [0:MAX_MSG_BYTES-1][7:0] msg_bytes;
   logic [CNT_W-1:0]              cnt;
   logic                          armed;
   logic                          err_q;
   logic                          collecting, acc, ovf, clear_buf;
   logic                          timeout, ser_load, ser_done;

   assign collecting = (state == ST_IDLE) || (state == ST_COLLECT);
   assign acc        = s_valid && s_ready;
   assign ovf        = acc && collecting && (cnt == CNT_W'(MAX_MSG_BYTES));
   assign ser_load   = (state == ST_WAIT) && hash_done;
   assign clear_buf  = (ovf && s_last)
                     || ((state == ST_DRAIN) && acc && s_last)
                     || ser_done
                     || timeout;

`ifdef SHA256_HOST_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                to_cnt <= '0;
      else if (state != ST_WAIT) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
   end

   // hash_done on the final cycle still wins over the watchdog.
   assign timeout = (state == ST_WAIT) && !hash_done
                 && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE, ST_COLLECT: begin
            if (acc) begin
               if (ovf)         nxt = s_last ? ST_IDLE : ST_DRAIN;
               else if (s_last) nxt = ST_ISSUE;
               else             nxt = ST_COLLECT;
            end
         end
         ST_ISSUE: nxt = ST_WAIT;
         ST_WAIT: begin
            if (hash_done)    nxt = ST_EMIT;
            else if (timeout) nxt = ST_IDLE;
         end
         ST_EMIT:  if (ser_done)       nxt = ST_IDLE;
         ST_DRAIN: if (acc && s_last)  nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready    = 1'b0;
      msg_valid  = 1'b0;
      data_valid = 1'b0;
      case (state)
         ST_IDLE, ST_COLLECT, ST_DRAIN: s_ready = armed;
         ST_ISSUE: begin
            msg_valid  = 1'b1;
            data_valid = 1'b1;
         end
         ST_WAIT:  data_valid = 1'b1;
         default:  ;
      endcase
   end

   // armed keeps s_ready low through the reset-release cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         err_q     <= 1'b0;
         cnt       <= '0;
         msg_bytes <= '0;
      end else begin
         armed <= 1'b1;
         err_q <= ovf || timeout;
         if (clear_buf) begin
            cnt       <= '0;
            msg_bytes <= '0;
         end else if (acc && collecting && !ovf) begin
            msg_bytes[cnt] <= s_data;
            cnt            <= cnt + 1'b1;
         end
      end
   end

   assign data_in    = msg_bytes;
   assign byte_valid = cnt;
   assign err        = err_q;

   sha256_digest_serializer u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ser_load),
      .load_data (fin_hash),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .done      (ser_done)
   );
endmodule

// File: tb/tb_sha256_msg_host.sv
// Scoreboard bench for sha256_msg_host: packing, issue, digest streaming, overflow, reset.
module tb_sha256_msg_host;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   s_data = '0;
   logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
   logic [439:0] data_in;
   logic [5:0]   byte_valid;
   logic         data_valid, msg_valid;
   logic [255:0] fin_hash = '0;
   logic         hash_done = 1'b0;
   logic [7:0]   m_data;
   logic         m_valid, m_last;
   logic         m_ready = 1'b1;
   logic         err;

   int n_chk = 0, n_err = 0;
   int n_msg = 0, n_errp = 0, n_mv = 0, n_hs = 0;
   logic [8:0] exp_q[$];
   logic [7:0] msg [0:63];

   localparam logic [255:0] ABC_DIG =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   sha256_msg_host #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .data_in(data_in), .byte_valid(byte_valid), .data_valid(data_valid),
      .msg_valid(msg_valid), .fin_hash(fin_hash), .hash_done(hash_done),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output monitor: pulse counters, stall-hold check, scoreboard pop.
   logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [7:0] pd = '0;
   logic [8:0] e;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (msg_valid) n_msg++;
         if (err)       n_errp++;
         if (m_valid)   n_mv++;
         if (pv && !pr) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, pl, pd});
         if (m_valid && m_ready) begin
            n_hs++;
            if (exp_q.size() == 0) chk("dig_underflow", m_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("dig_byte", m_data, e[7:0]);
               chk("dig_last", m_last, e[8]);
            end
         end
         pv = m_valid; pr = m_ready; pl = m_last; pd = m_data;
      end
   end

   function automatic logic [439:0] build_din(input int n);
      logic [439:0] d;
      d = '0;
      for (int i = 0; i < n && i < 55; i++) d[439 - 8*i -: 8] = msg[i];
      return d;
   endfunction

   function automatic logic [255:0] rand_dig();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   task automatic push_digest(input logic [255:0] dig);
      for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), dig[255 - 8*i -: 8]});
   endtask

   task automatic set_abc();
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
   endtask

   // All stimulus tasks start and end at posedge+1.
   task automatic send_msg(input int n);
      for (int i = 0; i < n; i++) begin
         s_data = msg[i]; s_valid = 1'b1; s_last = (i == n - 1);
         @(negedge clk);
         chk("s_ready", s_ready, 1);
         @(posedge clk); #1;
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_ctl", {s_ready, data_valid, msg_valid, m_valid, m_last, err}, 0);
      chk("rst_bv", byte_valid, 0);
      chk("rst_mdata", m_data, 0);
      chk("rst_din", data_in, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; hash_done = 1'b0; m_ready = 1'b1;
      exp_q.delete();
      #2 chk_reset_vals();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_rise", s_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_txn(input int n, input logic [255:0] dig, input bit stall);
      logic [439:0] ed;
      logic [3:0]   pat;
      int           msg0, errp0;
      ed = build_din(n); pat = 4'b1001;
      msg0 = n_msg; errp0 = n_errp; n_hs = 0;
      send_msg(n);
      @(negedge clk);
      chk("issue_pulse", msg_valid, 1);
      chk("issue_dv", data_valid, 1);
      chk("issue_bv", byte_valid, n);
      chk("issue_din", data_in, ed);
      @(negedge clk);
      chk("issue_once", msg_valid, 0);
      chk("wait_dv", data_valid, 1);
      chk("wait_din", data_in, ed);
      chk("wait_bv", byte_valid, n);
      @(posedge clk); #1;
      push_digest(dig); fin_hash = dig; hash_done = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      hash_done = 1'b0; fin_hash = rand_dig();
      @(negedge clk);
      chk("emit_lat", m_valid, 1);
      chk("emit_dv", data_valid, 0);
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (stall) m_ready = pat[3 - ((k + 1) % 4)];
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge clk); #1 m_ready = 1'b1;
      @(negedge clk);
      chk("emit_end", m_valid, 0);
      chk("idle_ready", s_ready, 1);
      chk("handshakes", n_hs, 32);
      chk("msg_count", n_msg - msg0, 1);
      chk("no_err", n_errp - errp0, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int msg0, errp0, mv0, cyc;
      do_reset();

      // hash_done outside WAIT is ignored
      fin_hash = rand_dig(); hash_done = 1'b1;
      @(posedge clk); #1 hash_done = 1'b0;
      @(negedge clk);
      chk("stray_done", m_valid, 0);
      @(posedge clk); #1;

      set_abc();
      do_txn(3, ABC_DIG, 1'b0);

      for (int i = 0; i < 55; i++) msg[i] = 8'(i * 7 + 3);
      do_txn(55, rand_dig(), 1'b0);

      // overflow: 60 bytes, last on byte 60
      for (int i = 0; i < 60; i++) msg[i] = 8'(i + 16);
      msg0 = n_msg; errp0 = n_errp;
      send_msg(60);
      repeat (3) @(negedge clk);
      chk("ovf_err", n_errp - errp0, 1);
      chk("ovf_no_issue", n_msg - msg0, 0);
      chk("ovf_ready", s_ready, 1);
      chk("ovf_clear", data_in, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) msg[i] = 8'($urandom());
      do_txn(5, rand_dig(), 1'b1);

`ifdef SHA256_HOST_TIMEOUT_EN
      set_abc();
      mv0 = n_mv; cyc = 0;
      send_msg(3);
      @(negedge clk);
      chk("to_issue", msg_valid, 1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (err) break;
         if (data_valid && !msg_valid) cyc++;
      end
      chk("to_err", err, 1);
      chk("to_cycles", cyc, 16);
      chk("to_dv", data_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_err_pulse", err, 0);
      chk("to_no_mvalid", n_mv - mv0, 0);
      chk("to_ready", s_ready, 1);
      @(posedge clk); #1;
`endif

      // reset while waiting for the core
      set_abc();
      send_msg(3);
      repeat (3) begin @(posedge clk); #1; end
      do_reset();
      do_txn(3, ABC_DIG, 1'b0);

      // reset part-way through the digest stream
      set_abc();
      send_msg(3);
      repeat (2) begin @(posedge clk); #1; end
      push_digest(ABC_DIG); fin_hash = ABC_DIG; hash_done = 1'b1;
      @(posedge clk); #1 hash_done = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      do_reset();
      do_txn(3, ABC_DIG, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end
endmodule

// File: doc/sha256_msg_host.md
# sha256_msg_host

Host-side initiator for the single-block SHA-256 core interface. Accepts a message as a byte stream and packs it MSB-first into the 440-bit message bus. Issues the message to the core and waits for `hash_done`. Captures `fin_hash` and returns the 32-byte digest as a backpressured byte stream. Sits between a byte-wide source (UART/DMA bridge) and the hash core, driving every core-side input of the SHA-256 interface.

## Interface
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles (used only with the config macro).
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data`  in  8  message byte.
- `s_valid`  in  1  byte present.
- `s_last`  in  1  final byte of message.
- `s_ready`  out  1  byte accepted when `s_valid && s_ready`.
- `data_in`  out  440  packed message; byte k at `[439-8k -: 8]`.
- `byte_valid`  out  6  message length in bytes, 1..55.
- `data_valid`  out  1  `data_in`/`byte_valid` valid and stable.
- `msg_valid`  out  1  one-cycle start pulse to core.
- `fin_hash`  in  256  digest from core.
- `hash_done`  in  1  digest valid.
- `m_data`  out  8  digest byte, `fin_hash[255:248]` first.
- `m_valid`  out  1  digest byte present.
- `m_last`  out  1  high with byte 31.
- `m_ready`  in  1  sink accepts byte.
- `err`  out  1  one-cycle pulse on overflow or timeout.

## Operation
- States: IDLE, COLLECT, ISSUE, WAIT, EMIT, DRAIN.
- IDLE/COLLECT: `s_ready`=1. Each accepted byte is written at index `cnt`, and `cnt` increments (6-bit). IDLE→COLLECT on the first accepted byte without `s_last`.
- Accepted byte with `s_last` and final count ≤55 → ISSUE.
- Accepted byte without `s_last` when `cnt`=55 (the 56th byte) → DRAIN. `err` pulses. No core request is made.
- DRAIN: `s_ready`=1. Bytes are discarded until `s_last` is accepted, then → IDLE. The buffer is cleared.
- ISSUE (one cycle): `msg_valid`=1 and `data_valid`=1. `byte_valid`=cnt. Unused bytes of `data_in` are 0. → WAIT.
- WAIT: `data_valid` is held at 1, and `data_in`/`byte_valid` stay stable. On `hash_done`=1, `fin_hash` is captured into the shift register, `data_valid` drops, and the state → EMIT.
- EMIT: `s_ready`=0. Shifts out bytes 0..31 on each `m_valid && m_ready`. `m_last` is high on byte 31. After the last handshake → IDLE, and `cnt` and the buffer are cleared.
- `hash_done` is ignored outside WAIT.
- Minimum message is 1 byte; a zero-length message is not supported.

## Timing
- Reset values: `s_ready`=0, `data_in`=0, `byte_valid`=0, `data_valid`=0, `msg_valid`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `err`=0. State is IDLE, all counters are 0. `s_ready` rises in the first cycle after reset release.
- `s_last` accepted at edge N → `msg_valid` high during cycle N+1.
- `hash_done` sampled at edge M → `m_valid` high from cycle M+1 → at most 32 cycles to drain with `m_ready` held high.
- `m_data`/`m_last` hold while `m_valid && !m_ready`.
- Reset asserted mid-operation (any state) → all outputs return to reset values immediately, and the partial message or digest is lost.

## Configuration
- `SHA256_HOST_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - Reaching `TIMEOUT_CYCLES` without `hash_done` → `err` pulse, `data_valid` drops, state → IDLE, and no digest is emitted.
- Undefined: WAIT lasts indefinitely, and the counter and parameter use are compiled out.

## Structure
- `sha256_pkg`:
  - `MAX_MSG_BYTES`=55, `DIGEST_BYTES`=32, `MSG_W`=440, `HASH_W`=256.
  - The host state enum typedef.
- Sub-module `sha256_digest_serializer`: loads 256 bits and emits 32 bytes with valid/ready/last. EMIT delegates to it.

## Test plan
- Stream "abc" (0x61,0x62,0x63, last on 0x63) → `data_in[439:416]`=0x616263, rest 0, `byte_valid`=3, one `msg_valid` pulse. Model returns ba7816bf…f20015ad → `m_data` sequence starts 0xba, ends 0xad with `m_last`.
- 55-byte message → `byte_valid`=55, byte 54 at `data_in[7:0]`, `err`=0.
- 56 bytes then 4 more with last on byte 60 → one `err` pulse at byte 56, no `msg_valid`, `s_ready` stays 1 until `s_last`, back to IDLE.
- `m_ready` toggled 1-0-0-1 during EMIT → each byte is held while stalled, exactly 32 handshakes, no duplicates.
- With `SHA256_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no `hash_done` → `err` after 16 WAIT cycles, `data_valid`=0, `m_valid` never asserted.
- `rst_n` pulsed low in WAIT and again mid-EMIT → outputs at reset values, a following "abc" transaction completes correctly.
